time_count: RTL and testbench



---
 rtl/time_count_pkg.sv | 60 ++++++
 rtl/tick_divider.sv | 57 +++++
 rtl/time_count.sv | 120 ++++++++++++
 tb/tb_time_count.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_count_pkg.sv
// -----------------------------------------------------------------------------
// time_count_pkg
// Shared types, constants and helpers for the tron game timebase.
//   seg7_t      : seven-segment pattern, bit0=a .. bit6=g, active-low
//   bcd_t       : one decimal digit
//   SEG_*       : digit patterns 0..9 plus SEG_BLANK
//   *_DEF       : board default divisors for a 50 MHz clock
//   seg7_decode : digit -> segment pattern (blank for non-decimal codes)
//   bcd_next    : digit increment that wraps to 0 after a given limit
// -----------------------------------------------------------------------------
package time_count_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] bcd_t;

  localparam seg7_t SEG_0     = 7'b1000000;
  localparam seg7_t SEG_1     = 7'b1111001;
  localparam seg7_t SEG_2     = 7'b0100100;
  localparam seg7_t SEG_3     = 7'b0110000;
  localparam seg7_t SEG_4     = 7'b0011001;
  localparam seg7_t SEG_5     = 7'b0010010;
  localparam seg7_t SEG_6     = 7'b0000010;
  localparam seg7_t SEG_7     = 7'b1111000;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0010000;
  localparam seg7_t SEG_BLANK = 7'b1111111;

  localparam int unsigned CLK_HZ_DEF   = 32'd50000000;
  localparam int unsigned FAST_DIV_DEF = 32'd833333;
  localparam int unsigned HALF_DIV_DEF = 32'd2;

  function automatic seg7_t seg7_decode(input bcd_t d);
    seg7_t s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic bcd_t bcd_next(input bcd_t d, input bcd_t limit);
    bcd_t n;
    if (d == limit) begin
      n = 4'd0;
    end else begin
      n = d + 4'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// -----------------------------------------------------------------------------
// tick_divider
// Divide-by-N strobe generator. While en is high a counter runs 0..N-1 and
// the registered tick is 1 for the cycle after the counter sat at N-1. While
// en is low the counter holds its phase and tick is 0.
//   CLOCK_50 : clock
//   resetn   : synchronous active-low reset (clears counter and tick)
//   en       : count enable
//   tick     : one-cycle strobe every N enabled cycles
// -----------------------------------------------------------------------------
module tick_divider #(
  parameter int unsigned N = 32'd2
) (
  input  logic CLOCK_50,
  input  logic resetn,
  input  logic en,
  output logic tick
);

  // N=1 still needs a 1-bit counter; it simply never leaves 0.
  localparam int unsigned W = (N > 32'd1) ? $clog2(N) : 32'd1;
  localparam logic [W-1:0] LAST = W'(N - 32'd1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  // Next counter value and strobe.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (en) begin
      tick_d = (cnt_q == LAST);
      if (cnt_q == LAST) begin
        cnt_d = {W{1'b0}};
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
    end
  end

  // Counter and strobe registers.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      cnt_q  <= {W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/time_count.sv
// -----------------------------------------------------------------------------
// time_count
// Game timebase for the tron board: two game-rate strobes plus an elapsed-time
// counter shown on four seven-segment displays.
//   CLOCK_50  : system clock, the only clock
//   resetn    : synchronous active-low reset, dominates all enables
//   div_en    : enables the fast and half dividers
//   count_en  : enables the elapsed-time counter (seconds divider and digits)
//   tick_fast : one-cycle strobe every FAST_DIV cycles
//   tick_half : one-cycle strobe every HALF_DIV cycles
//   HEX3..0   : digits d3..d0, active-low segments, decoded from the digit regs
// Build option: define TIME_COUNT_MINSEC_EN to show MM:SS instead of plain
// decimal seconds 0000..9999.
// -----------------------------------------------------------------------------
module time_count
  import time_count_pkg::*;
#(
  parameter int unsigned CLK_HZ   = CLK_HZ_DEF,
  parameter int unsigned FAST_DIV = FAST_DIV_DEF,
  parameter int unsigned HALF_DIV = HALF_DIV_DEF
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       div_en,
  input  logic       count_en,
  output logic       tick_fast,
  output logic       tick_half,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3
);

`ifdef TIME_COUNT_MINSEC_EN
  // Tens-of-seconds digit rolls over after 5 so seconds run 00..59.
  localparam bcd_t D1_LIMIT = 4'd5;
`else
  localparam bcd_t D1_LIMIT = 4'd9;
`endif
  localparam bcd_t D_LIMIT = 4'd9;

  logic tick_sec_s;
  logic c1_s, c2_s, c3_s;
  bcd_t d0_q, d1_q, d2_q, d3_q;
  bcd_t d0_d, d1_d, d2_d, d3_d;

  tick_divider #(.N(FAST_DIV)) u_fast (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .en       (div_en),
    .tick     (tick_fast)
  );

  tick_divider #(.N(HALF_DIV)) u_half (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .en       (div_en),
    .tick     (tick_half)
  );

  tick_divider #(.N(CLK_HZ)) u_sec (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .en       (count_en),
    .tick     (tick_sec_s)
  );

  // Ripple carry across the digits within one cycle; d3 wrapping gives the
  // full-display rollover to all zeros.
  always_comb begin
    c1_s = tick_sec_s & (d0_q == D_LIMIT);
    c2_s = c1_s & (d1_q == D1_LIMIT);
    c3_s = c2_s & (d2_q == D_LIMIT);
    d0_d = d0_q;
    d1_d = d1_q;
    d2_d = d2_q;
    d3_d = d3_q;
    if (tick_sec_s) begin
      d0_d = bcd_next(d0_q, D_LIMIT);
    end else begin
      d0_d = d0_q;
    end
    if (c1_s) begin
      d1_d = bcd_next(d1_q, D1_LIMIT);
    end else begin
      d1_d = d1_q;
    end
    if (c2_s) begin
      d2_d = bcd_next(d2_q, D_LIMIT);
    end else begin
      d2_d = d2_q;
    end
    if (c3_s) begin
      d3_d = bcd_next(d3_q, D_LIMIT);
    end else begin
      d3_d = d3_q;
    end
  end

  // Digit registers.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      d0_q <= 4'd0;
      d1_q <= 4'd0;
      d2_q <= 4'd0;
      d3_q <= 4'd0;
    end else begin
      d0_q <= d0_d;
      d1_q <= d1_d;
      d2_q <= d2_d;
      d3_q <= d3_d;
    end
  end

  assign HEX0 = seg7_decode(d0_q);
  assign HEX1 = seg7_decode(d1_q);
  assign HEX2 = seg7_decode(d2_q);
  assign HEX3 = seg7_decode(d3_q);

endmodule

// File: tb/tb_time_count.sv
// -----------------------------------------------------------------------------
// tb_time_count
// Directed bench for time_count. Main instance uses CLK_HZ=10, FAST_DIV=4,
// HALF_DIV=2. A second instance with CLK_HZ=1 reaches the display rollover in
// a few thousand cycles. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_time_count;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010;
  localparam logic [6:0] S9 = 7'b0010000;

  logic       clk = 1'b0;
  logic       resetn, div_en, count_en, w_count_en;
  logic       tick_fast, tick_half, w_tick_fast, w_tick_half;
  logic [6:0] hex0, hex1, hex2, hex3;
  logic [6:0] w_hex0, w_hex1, w_hex2, w_hex3;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  time_count #(.CLK_HZ(10), .FAST_DIV(4), .HALF_DIV(2)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .div_en   (div_en),
    .count_en (count_en),
    .tick_fast(tick_fast),
    .tick_half(tick_half),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3)
  );

  time_count #(.CLK_HZ(1), .FAST_DIV(4), .HALF_DIV(2)) dut_w (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .div_en   (1'b0),
    .count_en (w_count_en),
    .tick_fast(w_tick_fast),
    .tick_half(w_tick_half),
    .HEX0     (w_hex0),
    .HEX1     (w_hex1),
    .HEX2     (w_hex2),
    .HEX3     (w_hex3)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    chk(tag, {6'b0, obs}, {6'b0, exp});
  endtask

  task automatic chk_hex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                         input logic [6:0] e1, input logic [6:0] e0);
    chk({tag, "_hex3"}, hex3, e3);
    chk({tag, "_hex2"}, hex2, e2);
    chk({tag, "_hex1"}, hex1, e1);
    chk({tag, "_hex0"}, hex0, e0);
  endtask

  task automatic chk_whex(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                          input logic [6:0] e1, input logic [6:0] e0);
    chk({tag, "_hex3"}, w_hex3, e3);
    chk({tag, "_hex2"}, w_hex2, e2);
    chk({tag, "_hex1"}, w_hex1, e1);
    chk({tag, "_hex0"}, w_hex0, e0);
  endtask

  // Enable the fast-seconds instance for k edges, then let the last strobe land.
  task automatic w_run(input int k);
    w_count_en = 1'b1;
    step(k);
    w_count_en = 1'b0;
    step(2);
  endtask

  initial begin
    int wrap_k;
`ifdef TIME_COUNT_MINSEC_EN
    wrap_k = 5999;
`else
    wrap_k = 9999;
`endif
    resetn = 1'b0; div_en = 1'b0; count_en = 1'b0; w_count_en = 1'b0;

    // Reset state
    step(3);
    chk_bit("rst_fast", tick_fast, 1'b0);
    chk_bit("rst_half", tick_half, 1'b0);
    chk_hex("rst", S0, S0, S0, S0);
    chk_whex("rst_w", S0, S0, S0, S0);

    // Strobe cadence: fast after edges 4,8,12; half after 2,4,6,...
    resetn = 1'b1; div_en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      chk_bit("cad_fast", tick_fast, (i % 4) == 0);
      chk_bit("cad_half", tick_half, (i % 2) == 0);
    end

    // Reset while strobes are high clears them on the next edge
    resetn = 1'b0;
    step(1);
    chk_bit("rstmid_fast", tick_fast, 1'b0);
    chk_bit("rstmid_half", tick_half, 1'b0);

    // div_en dropped at cycle 6 for 5 cycles; phase held
    resetn = 1'b1;
    step(6);
    chk_bit("pre_drop_fast", tick_fast, 1'b0);
    chk_bit("pre_drop_half", tick_half, 1'b1);
    div_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk_bit("off_fast", tick_fast, 1'b0);
      chk_bit("off_half", tick_half, 1'b0);
    end
    div_en = 1'b1;
    step(1);
    chk_bit("resume1_fast", tick_fast, 1'b0);
    chk_bit("resume1_half", tick_half, 1'b0);
    step(1);
    chk_bit("resume2_fast", tick_fast, 1'b1);
    chk_bit("resume2_half", tick_half, 1'b1);

    // Seconds counting: d0 steps near cycles 10 and 20
    div_en = 1'b0; resetn = 1'b0;
    step(1);
    resetn = 1'b1; count_en = 1'b1;
    step(9);
    chk("sec9_hex0", hex0, S0);
    step(3);
    chk("sec12_hex0", hex0, S1);
    step(7);
    chk("sec19_hex0", hex0, S1);
    step(3);
    chk("sec22_hex0", hex0, S2);
    step(8);
    chk_hex("sec30", S0, S0, S0, S2);

    // count_en pause at cycle 15 for 7 cycles keeps phase
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    step(15);
    chk("pause_pre_hex0", hex0, S1);
    count_en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      chk("paused_hex0", hex0, S1);
    end
    count_en = 1'b1;
    step(4);
    chk("resume26_hex0", hex0, S1);
    step(2);
    chk("resume28_hex0", hex0, S2);

    // Count to 0042, reset mid-count, restart from phase 0
    resetn = 1'b0;
    step(1);
    resetn = 1'b1; div_en = 1'b1;
    step(425);
    chk_hex("d42", S0, S0, S4, S2);
    resetn = 1'b0;
    step(1);
    chk_hex("d42_rst", S0, S0, S0, S0);
    chk_bit("d42_rst_fast", tick_fast, 1'b0);
    chk_bit("d42_rst_half", tick_half, 1'b0);
    resetn = 1'b1;
    step(3);
    chk_bit("restart3_fast", tick_fast, 1'b0);
    step(1);
    chk_bit("restart4_fast", tick_fast, 1'b1);
    step(5);
    chk("restart9_hex0", hex0, S0);
    step(3);
    chk("restart12_hex0", hex0, S1);

    // Long count and rollover on the CLK_HZ=1 instance
    div_en = 1'b0; count_en = 1'b0; resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    w_run(600);
`ifdef TIME_COUNT_MINSEC_EN
    chk_whex("w600", S1, S0, S0, S0);
`else
    chk_whex("w600", S0, S6, S0, S0);
`endif
    w_run(wrap_k - 600);
`ifdef TIME_COUNT_MINSEC_EN
    chk_whex("wmax", S9, S9, S5, S9);
`else
    chk_whex("wmax", S9, S9, S9, S9);
`endif
    chk_bit("w_fast_idle", w_tick_fast, 1'b0);
    chk_bit("w_half_idle", w_tick_half, 1'b0);
    w_run(1);
    chk_whex("wwrap", S0, S0, S0, S0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
